// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - RTC register addresses, local indices and sequencer state encoding
package rtc_pkg;

  localparam int IDX_W   = 4;
  localparam int TIMER_W = 8;

  localparam logic [7:0] RTC_SEC     = 8'h21;
  localparam logic [7:0] RTC_MIN     = 8'h22;
  localparam logic [7:0] RTC_HOUR    = 8'h23;
  localparam logic [7:0] RTC_DAY     = 8'h24;
  localparam logic [7:0] RTC_MONTH   = 8'h25;
  localparam logic [7:0] RTC_YEAR    = 8'h26;
  localparam logic [7:0] RTC_WEEKDAY = 8'h27;
  localparam logic [7:0] RTC_T_SEC   = 8'h41;
  localparam logic [7:0] RTC_T_MIN   = 8'h42;
  localparam logic [7:0] RTC_T_HOUR  = 8'h43;

  // Local indices shared with the register distributor
  localparam logic [IDX_W-1:0] IDX_SEC     = 4'd0;
  localparam logic [IDX_W-1:0] IDX_MIN     = 4'd1;
  localparam logic [IDX_W-1:0] IDX_HOUR    = 4'd2;
  localparam logic [IDX_W-1:0] IDX_DAY     = 4'd3;
  localparam logic [IDX_W-1:0] IDX_MONTH   = 4'd4;
  localparam logic [IDX_W-1:0] IDX_YEAR    = 4'd5;
  localparam logic [IDX_W-1:0] IDX_WEEKDAY = 4'd6;
  localparam logic [IDX_W-1:0] IDX_T_SEC   = 4'd7;
  localparam logic [IDX_W-1:0] IDX_T_MIN   = 4'd8;
  localparam logic [IDX_W-1:0] IDX_T_HOUR  = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_GAP1 = 3'd2,
    ST_DATA = 3'd3,
    ST_GAP2 = 3'd4,
    ST_DONE = 3'd5
  } rtc_state_t;

endpackage

// File: rtl/rtc_addr_rom.sv
// rtl/rtc_addr_rom.sv - combinational local index to RTC register address lookup
module rtc_addr_rom
  import rtc_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [7:0]       addr
);

  always_comb begin
    addr = 8'h00;
    case (idx)
      IDX_SEC:     addr = RTC_SEC;
      IDX_MIN:     addr = RTC_MIN;
      IDX_HOUR:    addr = RTC_HOUR;
      IDX_DAY:     addr = RTC_DAY;
      IDX_MONTH:   addr = RTC_MONTH;
      IDX_YEAR:    addr = RTC_YEAR;
      IDX_WEEKDAY: addr = RTC_WEEKDAY;
      IDX_T_SEC:   addr = RTC_T_SEC;
      IDX_T_MIN:   addr = RTC_T_MIN;
      IDX_T_HOUR:  addr = RTC_T_HOUR;
      default:     addr = 8'h00;
    endcase
  end

endmodule

// File: rtl/rtc_read_sequencer.sv
// rtl/rtc_read_sequencer.sv - sweeps the RTC registers over the multiplexed A/D bus
module rtc_read_sequencer
  import rtc_pkg::*;
#(
  parameter int T_PHASE = 10,
  parameter int T_GAP   = 4,
  parameter int N_REGS  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       ad_in,
  output logic [7:0]       ad_out,
  output logic             ad_oe,
  output logic             cs_n,
  output logic             rd_n,
  output logic             wr_n,
  output logic             a_d_n,
  output logic [IDX_W-1:0] out_addr_mem_local,
  output logic [7:0]       out_dato_rtc,
  output logic             dato_valido,
  output logic             busy,
  output logic             sweep_done
);

  localparam logic [TIMER_W-1:0] PHASE_LOAD = TIMER_W'(T_PHASE - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(T_GAP - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(N_REGS - 1);

  rtc_state_t         state;
  logic [TIMER_W-1:0] timer;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   rom_idx;
  logic [7:0]         rom_addr;

  // ROM looks up the index of the ADDR phase about to be entered
  assign rom_idx = (state == ST_GAP2) ? idx + 4'd1 : '0;

  rtc_addr_rom u_rom (
    .idx  (rom_idx),
    .addr (rom_addr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= ST_IDLE;
      timer              <= '0;
      idx                <= '0;
      ad_out             <= 8'h00;
      ad_oe              <= 1'b0;
      cs_n               <= 1'b1;
      rd_n               <= 1'b1;
      wr_n               <= 1'b1;
      a_d_n              <= 1'b1;
      out_addr_mem_local <= '0;
      out_dato_rtc       <= 8'h00;
      dato_valido        <= 1'b0;
      busy               <= 1'b0;
      sweep_done         <= 1'b0;
    end else begin
      dato_valido <= 1'b0;
      sweep_done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_ADDR;
            timer  <= PHASE_LOAD;
            idx    <= '0;
            busy   <= 1'b1;
            cs_n   <= 1'b0;
            a_d_n  <= 1'b0;
            wr_n   <= 1'b0;
            ad_oe  <= 1'b1;
            ad_out <= rom_addr;
          end
        end
        ST_ADDR: begin
          if (timer == '0) begin
            // Release the bus in the first gap cycle so the RTC can turn it around
            state  <= ST_GAP1;
            timer  <= GAP_LOAD;
            cs_n   <= 1'b1;
            wr_n   <= 1'b1;
            ad_oe  <= 1'b0;
            ad_out <= 8'h00;
            a_d_n  <= 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_GAP1: begin
          if (timer == '0) begin
            state <= ST_DATA;
            timer <= PHASE_LOAD;
            cs_n  <= 1'b0;
            rd_n  <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_DATA: begin
          if (timer == '0) begin
            state              <= ST_GAP2;
            timer              <= GAP_LOAD;
            cs_n               <= 1'b1;
            rd_n               <= 1'b1;
            out_dato_rtc       <= ad_in;
            out_addr_mem_local <= idx;
            dato_valido        <= 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_GAP2: begin
          if (timer == '0) begin
            if (idx == LAST_IDX) begin
              state      <= ST_DONE;
              sweep_done <= 1'b1;
            end else begin
              state  <= ST_ADDR;
              timer  <= PHASE_LOAD;
              idx    <= idx + 1'b1;
              cs_n   <= 1'b0;
              a_d_n  <= 1'b0;
              wr_n   <= 1'b0;
              ad_oe  <= 1'b1;
              ad_out <= rom_addr;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_read_sequencer.sv
// tb/tb_rtc_read_sequencer.sv - directed self-checking bench for rtc_read_sequencer
module tb_rtc_read_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe, cs_n, rd_n, wr_n, a_d_n;
  logic [3:0] out_addr_mem_local;
  logic [7:0] out_dato_rtc;
  logic       dato_valido, busy, sweep_done;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rtc_read_sequencer #(.T_PHASE(4), .T_GAP(2), .N_REGS(10)) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .ad_in              (ad_in),
    .ad_out             (ad_out),
    .ad_oe              (ad_oe),
    .cs_n               (cs_n),
    .rd_n               (rd_n),
    .wr_n               (wr_n),
    .a_d_n              (a_d_n),
    .out_addr_mem_local (out_addr_mem_local),
    .out_dato_rtc       (out_dato_rtc),
    .dato_valido        (dato_valido),
    .busy               (busy),
    .sweep_done         (sweep_done)
  );

  logic [7:0] exp_addr [10] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25,
                                8'h26, 8'h27, 8'h41, 8'h42, 8'h43};

  // RTC model: latches the address phase, answers 50h + index on reads
  function automatic logic [7:0] addr_to_idx(input logic [7:0] a);
    case (a)
      8'h21: return 8'd0;
      8'h22: return 8'd1;
      8'h23: return 8'd2;
      8'h24: return 8'd3;
      8'h25: return 8'd4;
      8'h26: return 8'd5;
      8'h27: return 8'd6;
      8'h41: return 8'd7;
      8'h42: return 8'd8;
      8'h43: return 8'd9;
      default: return 8'h9E;
    endcase
  endfunction

  logic [7:0] rtc_addr = 8'h00;
  always @(posedge clk)
    if (!cs_n && !wr_n && !a_d_n && ad_oe) rtc_addr <= ad_out;
  assign ad_in = 8'h50 + addr_to_idx(rtc_addr);

  int         v_cyc[$];
  logic [3:0] v_idx[$];
  logic [7:0] v_dat[$];
  int         d_cyc[$];
  logic [7:0] a_seen[$];
  logic       prev_wr_n = 1'b1;
  int both_low = 0, oe_rd = 0, bad_len = 0, runs = 0, wr_run = 0, rd_run = 0;

  always @(negedge clk) begin
    if (dato_valido) begin
      v_cyc.push_back(cyc);
      v_idx.push_back(out_addr_mem_local);
      v_dat.push_back(out_dato_rtc);
    end
    if (sweep_done) d_cyc.push_back(cyc);
    if (!wr_n && prev_wr_n) a_seen.push_back(ad_out);
    prev_wr_n = wr_n;
    if (!wr_n && !rd_n) both_low++;
    if (ad_oe && !rd_n) oe_rd++;
    if (reset) begin
      wr_run = 0;
      rd_run = 0;
    end else begin
      if (!wr_n) wr_run++;
      else begin
        if (wr_run != 0) begin
          if (wr_run != 4) bad_len++;
          runs++;
        end
        wr_run = 0;
      end
      if (!rd_n) rd_run++;
      else begin
        if (rd_run != 0) begin
          if (rd_run != 4) bad_len++;
          runs++;
        end
        rd_run = 0;
      end
    end
  end

  task automatic clear_log();
    v_cyc.delete(); v_idx.delete(); v_dat.delete(); d_cyc.delete(); a_seen.delete();
  endtask

  task automatic test_reset();
    int bad = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    clear_log();
    repeat (20) begin
      @(negedge clk);
      if (!cs_n || !rd_n || !wr_n || !a_d_n || ad_oe || busy || sweep_done) bad++;
    end
    tot_cnt++;
    if (bad !== 0) $display("FAIL reset_idle_bus: active cycles %0d, required 0", bad);
    else pass_cnt++;
    tot_cnt++;
    if (v_cyc.size() !== 0) $display("FAIL reset_no_valid: valids %0d, required 0", v_cyc.size());
    else pass_cnt++;
    tot_cnt++;
    if ({ad_out, out_dato_rtc, out_addr_mem_local} !== 20'h0)
      $display("FAIL reset_regs: %h, required 00000", {ad_out, out_dato_rtc, out_addr_mem_local});
    else pass_cnt++;
  endtask

  task automatic check_sweep(input int s, input string tag);
    tot_cnt++;
    if (v_cyc.size() !== 10) $display("FAIL %s_valid_count: %0d, required 10", tag, v_cyc.size());
    else pass_cnt++;
    tot_cnt++;
    if (a_seen.size() !== 10) $display("FAIL %s_addr_count: %0d, required 10", tag, a_seen.size());
    else pass_cnt++;
    for (int k = 0; k < 10; k++) begin
      if (k < v_cyc.size()) begin
        tot_cnt++;
        if (v_cyc[k] - s !== 12 * k + 11)
          $display("FAIL %s_valid_cycle[%0d]: %0d, required %0d", tag, k, v_cyc[k] - s, 12 * k + 11);
        else pass_cnt++;
        tot_cnt++;
        if (v_idx[k] !== 4'(k)) $display("FAIL %s_valid_idx[%0d]: %0d, required %0d", tag, k, v_idx[k], k);
        else pass_cnt++;
        tot_cnt++;
        if (v_dat[k] !== 8'h50 + 8'(k))
          $display("FAIL %s_valid_data[%0d]: %h, required %h", tag, k, v_dat[k], 8'h50 + 8'(k));
        else pass_cnt++;
      end
      if (k < a_seen.size()) begin
        tot_cnt++;
        if (a_seen[k] !== exp_addr[k])
          $display("FAIL %s_ad_out[%0d]: %h, required %h", tag, k, a_seen[k], exp_addr[k]);
        else pass_cnt++;
      end
    end
    tot_cnt++;
    if (d_cyc.size() !== 1) $display("FAIL %s_done_count: %0d, required 1", tag, d_cyc.size());
    else pass_cnt++;
    if (d_cyc.size() > 0) begin
      tot_cnt++;
      if (d_cyc[0] - s !== 121) $display("FAIL %s_done_cycle: %0d, required 121", tag, d_cyc[0] - s);
      else pass_cnt++;
    end
    tot_cnt++;
    if (busy !== 1'b0) $display("FAIL %s_busy_after: %b, required 0", tag, busy);
    else pass_cnt++;
  endtask

  task automatic run_sweep(input bit extra, input string tag);
    int s;
    @(negedge clk);
    clear_log();
    s = cyc;
    start = 1'b1;
    for (int i = 1; i <= 140; i++) begin
      @(negedge clk);
      start = extra && ((cyc - s == 5) || (cyc - s == 60));
    end
    start = 1'b0;
    check_sweep(s, tag);
  endtask

  task automatic test_single_sweep();
    run_sweep(1'b0, "sweep");
  endtask

  task automatic test_ignored_starts();
    run_sweep(1'b1, "extra_start");
  endtask

  task automatic test_reset_mid_sweep();
    int n = 0;
    @(negedge clk);
    clear_log();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (v_cyc.size() < 5 && n < 200) begin @(negedge clk); n++; end
    while (rd_n !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    tot_cnt++;
    if (n >= 200) $display("FAIL midreset_reach_data5: timeout after %0d cycles, required < 200", n);
    else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    tot_cnt++;
    if ({cs_n, ad_oe, rd_n, busy} !== 4'b1010)
      $display("FAIL midreset_async: cs_n,ad_oe,rd_n,busy=%b, required 1010", {cs_n, ad_oe, rd_n, busy});
    else pass_cnt++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    tot_cnt++;
    if (v_cyc.size() !== 5) $display("FAIL midreset_no_partial: valids %0d, required 5", v_cyc.size());
    else pass_cnt++;
    run_sweep(1'b0, "restart");
  endtask

  task automatic test_back_to_back();
    int s;
    @(negedge clk);
    clear_log();
    s = cyc;
    start = 1'b1;
    for (int i = 1; i <= 270; i++) begin
      @(negedge clk);
      if (cyc - s == 122) begin
        tot_cnt++;
        if (busy !== 1'b0) $display("FAIL b2b_idle_gap: busy %b, required 0", busy);
        else pass_cnt++;
      end
      if (cyc - s == 123) begin
        tot_cnt++;
        if (busy !== 1'b1) $display("FAIL b2b_restart: busy %b, required 1", busy);
        else pass_cnt++;
      end
      if (cyc - s >= 244) start = 1'b0;
    end
    tot_cnt++;
    if (v_cyc.size() !== 20) $display("FAIL b2b_valid_count: %0d, required 20", v_cyc.size());
    else pass_cnt++;
    tot_cnt++;
    if (d_cyc.size() !== 2) $display("FAIL b2b_done_count: %0d, required 2", d_cyc.size());
    else pass_cnt++;
    if (v_cyc.size() > 10) begin
      tot_cnt++;
      if (v_cyc[10] - s !== 133 || v_idx[10] !== 4'd0)
        $display("FAIL b2b_second_first: cycle %0d idx %0d, required 133 idx 0", v_cyc[10] - s, v_idx[10]);
      else pass_cnt++;
    end
    if (d_cyc.size() > 1) begin
      tot_cnt++;
      if (d_cyc[1] - s !== 243) $display("FAIL b2b_second_done: %0d, required 243", d_cyc[1] - s);
      else pass_cnt++;
    end
  endtask

  task automatic test_protocol();
    tot_cnt++;
    if (both_low !== 0) $display("FAIL proto_wr_rd_low: %0d cycles, required 0", both_low);
    else pass_cnt++;
    tot_cnt++;
    if (oe_rd !== 0) $display("FAIL proto_oe_rd: %0d cycles, required 0", oe_rd);
    else pass_cnt++;
    tot_cnt++;
    if (bad_len !== 0) $display("FAIL proto_strobe_len: %0d bad runs, required 0", bad_len);
    else pass_cnt++;
    tot_cnt++;
    if (runs !== 111) $display("FAIL proto_strobe_runs: %0d, required 111", runs);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_sweep();
    test_ignored_starts();
    test_reset_mid_sweep();
    test_back_to_back();
    test_protocol();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
